// File: rtl/wbu.sv
// Write-back unit: retires one load/store-stage result at a time.
//   IDLE   : accepts a result (wbu_receive_valid) and latches every input.
//   COMMIT : writes the GPR (and CSRs / ecall trap state), computes the redirect.
//   SEND   : presents pc_redirect to fetch until ifu_ready completes the handshake.
// Optional feature macro: WBU_CSR_EN adds mstatus/mtvec/mepc/mcause and ecall trapping.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   wbu_receive_valid/ready        upstream handshake (ready == IDLE)
//   wd, rd, reg_write_en           GPR write request
//   csr_wd, csr_rd, csreg_write_en CSR write request (0 mstatus, 1 mtvec, 2 mepc, 3 mcause)
//   ecall, pc, pc_next             trap flag, retiring PC, sequential/branch successor
//   wbu_send_valid, ifu_ready      downstream handshake carrying pc_redirect
//   rs1/rs2_addr, rs1/rs2_data     combinational GPR reads
//   csr_raddr, csr_rdata           combinational CSR read
//   wbu_state                      busy (state != IDLE)
module wbu #(
  parameter int unsigned REG_NUM     = 32,
  parameter logic [31:0] ECALL_CAUSE = 32'd11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbu_receive_valid,
  output logic        wbu_receive_ready,
  input  logic [31:0] wd,
  input  logic [31:0] csr_wd,
  input  logic [4:0]  rd,
  input  logic [1:0]  csr_rd,
  input  logic        reg_write_en,
  input  logic        csreg_write_en,
  input  logic        ecall,
  input  logic [31:0] pc,
  input  logic [31:0] pc_next,
  output logic        wbu_send_valid,
  input  logic        ifu_ready,
  output logic [31:0] pc_redirect,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic [1:0]  csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        wbu_state
);

  localparam int unsigned MaxRegs = 32;

  typedef enum logic [1:0] {StIdle, StCommit, StSend} state_e;
  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (wbu_receive_valid) state_d = StCommit;
      StCommit: state_d = StSend;
      StSend:   if (ifu_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  logic accept, commit;
  assign accept            = (state_q == StIdle) && wbu_receive_valid;
  assign commit            = (state_q == StCommit);
  assign wbu_receive_ready = (state_q == StIdle);
  assign wbu_send_valid    = (state_q == StSend);
  assign wbu_state         = (state_q != StIdle);

  // Latched GPR request and successor PC.
  logic [31:0] wd_q, pc_next_q;
  logic [4:0]  rd_q;
  logic        reg_we_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q      <= '0;
      pc_next_q <= '0;
      rd_q      <= '0;
      reg_we_q  <= 1'b0;
    end else if (accept) begin
      wd_q      <= wd;
      pc_next_q <= pc_next;
      rd_q      <= rd;
      reg_we_q  <= reg_write_en;
    end
  end

  // GPR file: x0 and indices beyond REG_NUM are never written and read as zero.
  logic [31:0] gpr_q [MaxRegs];
  logic        gpr_we;
  assign gpr_we = commit && reg_we_q && (rd_q != 5'd0) && (32'(rd_q) < REG_NUM);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MaxRegs; i++) gpr_q[i] <= '0;
    end else if (gpr_we) begin
      gpr_q[rd_q] <= wd_q;
    end
  end

  assign rs1_data = ((rs1_addr != 5'd0) && (32'(rs1_addr) < REG_NUM)) ? gpr_q[rs1_addr] : '0;
  assign rs2_data = ((rs2_addr != 5'd0) && (32'(rs2_addr) < REG_NUM)) ? gpr_q[rs2_addr] : '0;

  logic [31:0] redirect_target;

`ifdef WBU_CSR_EN
  logic [31:0] mstatus_q, mtvec_q, mepc_q, mcause_q;
  logic [31:0] pc_q, csr_wd_q;
  logic [1:0]  csr_rd_q;
  logic        csr_we_q, ecall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q <= 32'h1800;
      mtvec_q   <= '0;
      mepc_q    <= '0;
      mcause_q  <= '0;
      pc_q      <= '0;
      csr_wd_q  <= '0;
      csr_rd_q  <= '0;
      csr_we_q  <= 1'b0;
      ecall_q   <= 1'b0;
    end else begin
      if (accept) begin
        pc_q     <= pc;
        csr_wd_q <= csr_wd;
        csr_rd_q <= csr_rd;
        csr_we_q <= csreg_write_en;
        ecall_q  <= ecall;
      end
      if (commit) begin
        // An ecall owns the CSR write port; a concurrent CSR write is dropped.
        if (ecall_q) begin
          mepc_q   <= pc_q;
          mcause_q <= ECALL_CAUSE;
        end else if (csr_we_q) begin
          unique case (csr_rd_q)
            2'd0: mstatus_q <= csr_wd_q;
            2'd1: mtvec_q   <= csr_wd_q;
            2'd2: mepc_q    <= csr_wd_q;
            2'd3: mcause_q  <= csr_wd_q;
          endcase
        end
      end
    end
  end

  always_comb begin
    csr_rdata = '0;
    unique case (csr_raddr)
      2'd0: csr_rdata = mstatus_q;
      2'd1: csr_rdata = mtvec_q;
      2'd2: csr_rdata = mepc_q;
      2'd3: csr_rdata = mcause_q;
    endcase
  end

  // An ecall never writes mtvec, so the pre-commit value equals the post-commit one.
  assign redirect_target = ecall_q ? mtvec_q : pc_next_q;
`else
  logic unused_csr;
  assign unused_csr      = ^{csr_wd, csr_rd, csreg_write_en, ecall, pc, csr_raddr};
  assign csr_rdata       = '0;
  assign redirect_target = pc_next_q;
`endif

  // Registered so it holds steady for the whole SEND phase.
  logic [31:0] pc_redirect_q;
  always_ff @(posedge clk) begin
    if (rst)         pc_redirect_q <= '0;
    else if (commit) pc_redirect_q <= redirect_target;
  end
  assign pc_redirect = pc_redirect_q;

endmodule

// File: tb/tb_wbu.sv
module tb_wbu;

  localparam int unsigned REG_NUM     = 32;
  localparam logic [31:0] ECALL_CAUSE = 32'd11;
`ifdef WBU_CSR_EN
  localparam bit CsrEn = 1'b1;
`else
  localparam bit CsrEn = 1'b0;
`endif

  logic        clk, rst;
  logic        wbu_receive_valid, wbu_receive_ready;
  logic [31:0] wd, csr_wd, pc, pc_next, pc_redirect;
  logic [4:0]  rd, rs1_addr, rs2_addr;
  logic [1:0]  csr_rd, csr_raddr;
  logic        reg_write_en, csreg_write_en, ecall;
  logic        wbu_send_valid, ifu_ready, wbu_state;
  logic [31:0] rs1_data, rs2_data, csr_rdata;

  wbu #(.REG_NUM(REG_NUM), .ECALL_CAUSE(ECALL_CAUSE)) dut (
    .clk               (clk),
    .rst               (rst),
    .wbu_receive_valid (wbu_receive_valid),
    .wbu_receive_ready (wbu_receive_ready),
    .wd                (wd),
    .csr_wd            (csr_wd),
    .rd                (rd),
    .csr_rd            (csr_rd),
    .reg_write_en      (reg_write_en),
    .csreg_write_en    (csreg_write_en),
    .ecall             (ecall),
    .pc                (pc),
    .pc_next           (pc_next),
    .wbu_send_valid    (wbu_send_valid),
    .ifu_ready         (ifu_ready),
    .pc_redirect       (pc_redirect),
    .rs1_addr          (rs1_addr),
    .rs2_addr          (rs2_addr),
    .rs1_data          (rs1_data),
    .rs2_data          (rs2_data),
    .csr_raddr         (csr_raddr),
    .csr_rdata         (csr_rdata),
    .wbu_state         (wbu_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model and scoreboard of expected redirects.
  logic [31:0] exp_gpr [32];
  logic [31:0] exp_csr [4];
  logic [31:0] exp_q [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) exp_gpr[i] = '0;
    exp_csr[0] = 32'h1800;
    exp_csr[1] = '0;
    exp_csr[2] = '0;
    exp_csr[3] = '0;
    exp_q.delete();
  endtask

  function automatic logic [31:0] exp_csr_read(input logic [1:0] a);
    return CsrEn ? exp_csr[a] : 32'h0;
  endfunction

  // Presents one result for a single cycle (DUT must be idle) and updates the model.
  task automatic issue(input logic [4:0] r, input logic [31:0] d, input logic we,
                       input logic [31:0] p, input logic [31:0] pn, input logic cwe,
                       input logic [1:0] cr, input logic [31:0] cd, input logic ec);
    rd = r; wd = d; reg_write_en = we; pc = p; pc_next = pn;
    csreg_write_en = cwe; csr_rd = cr; csr_wd = cd; ecall = ec;
    wbu_receive_valid = 1'b1;
    if (we && r != 5'd0 && 32'(r) < REG_NUM) exp_gpr[r] = d;
    if (CsrEn) begin
      if (ec) begin
        exp_csr[2] = p;
        exp_csr[3] = ECALL_CAUSE;
      end else if (cwe) begin
        exp_csr[cr] = cd;
      end
    end
    exp_q.push_back((CsrEn && ec) ? exp_csr[1] : pn);
    step();
    wbu_receive_valid = 1'b0;
  endtask

  // Bounded wait for SEND, optional back-pressure, then handshake.
  task automatic wait_send(input int stall, output logic ok, output logic [31:0] seen);
    int n;
    n = 0;
    seen = '0;
    ifu_ready = (stall == 0);
    while (!wbu_send_valid && n < 8) begin
      step();
      n++;
    end
    ok = wbu_send_valid;
    if (!ok) begin
      ifu_ready = 1'b1;
      return;
    end
    for (int i = 0; i < stall; i++) step();
    seen = pc_redirect;
    ifu_ready = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifu_ready = 1'b0;
    wbu_receive_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    model_reset();
    vectors++;
    if (wbu_receive_ready !== 1'b1 || wbu_state !== 1'b0 || wbu_send_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got rr=%b st=%b sv=%b want rr=1 st=0 sv=0",
               wbu_receive_ready, wbu_state, wbu_send_valid);
    end
    vectors++;
    if (pc_redirect !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_redirect: got %h want 00000000", pc_redirect);
    end
    for (int i = 0; i < 4; i++) begin
      rs1_addr = 5'(i * 9);
      rs2_addr = 5'(31 - i);
      csr_raddr = 2'(i);
      #1;
      vectors++;
      if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_gpr %0d: got %h/%h want 0/0", i, rs1_data, rs2_data);
      end
      vectors++;
      if (csr_rdata !== exp_csr_read(2'(i))) begin
        miscompares++;
        $display("FAIL reset_csr %0d: got %h want %h", i, csr_rdata, exp_csr_read(2'(i)));
      end
    end
  endtask

  task automatic test_gpr_write();
    logic [31:0] exp;
    rs1_addr = 5'd5;
    ifu_ready = 1'b1;
    issue(5'd5, 32'hDEADBEEF, 1'b1, 32'h8000_0000, 32'h8000_0004, 1'b0, 2'd0, 32'h0, 1'b0);
    // In COMMIT: write not yet visible, nothing sent.
    vectors++;
    if (wbu_send_valid !== 1'b0 || wbu_receive_ready !== 1'b0 || wbu_state !== 1'b1) begin
      miscompares++;
      $display("FAIL commit_ctrl: got sv=%b rr=%b st=%b want 0 0 1",
               wbu_send_valid, wbu_receive_ready, wbu_state);
    end
    vectors++;
    if (rs1_data !== 32'h0) begin
      miscompares++;
      $display("FAIL no_bypass: got %h want 00000000", rs1_data);
    end
    step();
    exp = exp_q.pop_front();
    vectors++;
    if (wbu_send_valid !== 1'b1 || pc_redirect !== exp) begin
      miscompares++;
      $display("FAIL send_redirect: got sv=%b pc=%h want sv=1 pc=%h",
               wbu_send_valid, pc_redirect, exp);
    end
    vectors++;
    if (rs1_data !== exp_gpr[5]) begin
      miscompares++;
      $display("FAIL gpr_x5: got %h want %h", rs1_data, exp_gpr[5]);
    end
    step();
    vectors++;
    if (wbu_receive_ready !== 1'b1 || wbu_send_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency3: got rr=%b sv=%b want rr=1 sv=0", wbu_receive_ready, wbu_send_valid);
    end
  endtask

  task automatic test_x0();
    logic ok;
    logic [31:0] seen, exp;
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    issue(5'd0, 32'h1234, 1'b1, 32'h8000_0004, 32'h8000_0008, 1'b0, 2'd0, 32'h0, 1'b0);
    wait_send(0, ok, seen);
    exp = exp_q.pop_front();
    vectors++;
    if (!ok || seen !== exp) begin
      miscompares++;
      $display("FAIL x0_redirect: got ok=%b pc=%h want ok=1 pc=%h", ok, seen, exp);
    end
    vectors++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
      miscompares++;
      $display("FAIL x0_read: got %h/%h want 0/0", rs1_data, rs2_data);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    ifu_ready = 1'b0;
    issue(5'd7, 32'h0BAD_F00D, 1'b1, 32'h8000_0100, 32'h8000_0104, 1'b0, 2'd0, 32'h0, 1'b0);
    step();
    exp = exp_q.pop_front();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (wbu_send_valid !== 1'b1 || pc_redirect !== exp || wbu_receive_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold %0d: got sv=%b pc=%h rr=%b want sv=1 pc=%h rr=0",
                 i, wbu_send_valid, pc_redirect, wbu_receive_ready, exp);
      end
      // A second result offered while busy must be ignored.
      if (i == 1) begin
        rd = 5'd8; wd = 32'hFFFF_FFFF; reg_write_en = 1'b1; pc_next = 32'h1111_2222;
        wbu_receive_valid = 1'b1;
      end
      if (i == 2) wbu_receive_valid = 1'b0;
      step();
    end
    ifu_ready = 1'b1;
    step();
    vectors++;
    if (wbu_receive_ready !== 1'b1 || wbu_send_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_release: got rr=%b sv=%b want rr=1 sv=0",
               wbu_receive_ready, wbu_send_valid);
    end
    rs1_addr = 5'd7;
    rs2_addr = 5'd8;
    #1;
    vectors++;
    if (rs1_data !== exp_gpr[7] || rs2_data !== exp_gpr[8]) begin
      miscompares++;
      $display("FAIL stall_regs: got x7=%h x8=%h want x7=%h x8=%h",
               rs1_data, rs2_data, exp_gpr[7], exp_gpr[8]);
    end
  endtask

  task automatic test_rst_in_commit();
    rd = 5'd3; wd = 32'hA5A5_A5A5; reg_write_en = 1'b1; pc_next = 32'h8000_0200;
    csreg_write_en = 1'b0; ecall = 1'b0;
    wbu_receive_valid = 1'b1;
    step();
    wbu_receive_valid = 1'b0;
    vectors++;
    if (wbu_state !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre_commit: got st=%b want 1", wbu_state);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    rs1_addr = 5'd3;
    rs2_addr = 5'd5;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (wbu_state !== 1'b0 || wbu_send_valid !== 1'b0 || pc_redirect !== 32'h0) begin
        miscompares++;
        $display("FAIL rst_abort %0d: got st=%b sv=%b pc=%h want 0 0 00000000",
                 i, wbu_state, wbu_send_valid, pc_redirect);
      end
      vectors++;
      if (rs1_data !== exp_gpr[3] || rs2_data !== exp_gpr[5]) begin
        miscompares++;
        $display("FAIL rst_regs %0d: got x3=%h x5=%h want 0/0", i, rs1_data, rs2_data);
      end
      step();
    end
  endtask

`ifdef WBU_CSR_EN
  task automatic test_csr_ecall();
    logic ok;
    logic [31:0] seen, exp;
    issue(5'd0, 32'h0, 1'b0, 32'h8000_0020, 32'h8000_0024, 1'b1, 2'd1, 32'h8000_0100, 1'b0);
    wait_send(0, ok, seen);
    exp = exp_q.pop_front();
    vectors++;
    if (!ok || seen !== exp) begin
      miscompares++;
      $display("FAIL mtvec_write_redirect: got ok=%b pc=%h want %h", ok, seen, exp);
    end
    // Concurrent mcause write must be dropped by the ecall.
    issue(5'd0, 32'h0, 1'b0, 32'h8000_0040, 32'h8000_0044, 1'b1, 2'd3, 32'hFFFF, 1'b1);
    wait_send(1, ok, seen);
    exp = exp_q.pop_front();
    vectors++;
    if (!ok || seen !== exp) begin
      miscompares++;
      $display("FAIL ecall_redirect: got ok=%b pc=%h want %h", ok, seen, exp);
    end
    for (int i = 0; i < 4; i++) begin
      csr_raddr = 2'(i);
      #1;
      vectors++;
      if (csr_rdata !== exp_csr[i]) begin
        miscompares++;
        $display("FAIL ecall_csr %0d: got %h want %h", i, csr_rdata, exp_csr[i]);
      end
    end
  endtask
`else
  task automatic test_no_csr();
    logic ok;
    logic [31:0] seen, exp;
    issue(5'd0, 32'h0, 1'b0, 32'h8000_0000, 32'h8000_0004, 1'b1, 2'd1, 32'h1234_5678, 1'b1);
    wait_send(0, ok, seen);
    exp = exp_q.pop_front();
    vectors++;
    if (!ok || seen !== exp) begin
      miscompares++;
      $display("FAIL nocsr_redirect: got ok=%b pc=%h want %h", ok, seen, exp);
    end
    for (int i = 0; i < 4; i++) begin
      csr_raddr = 2'(i);
      #1;
      vectors++;
      if (csr_rdata !== 32'h0) begin
        miscompares++;
        $display("FAIL nocsr_rdata %0d: got %h want 00000000", i, csr_rdata);
      end
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic ok;
    logic [31:0] seen, exp;
    for (int t = 0; t < 12; t++) begin
      issue(5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)),
            {$urandom_range(0, 65535), 16'h0}, {16'h8000, 16'($urandom_range(0, 65535))},
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
            ($urandom_range(0, 3) == 0));
      wait_send(int'($urandom_range(0, 3)), ok, seen);
      exp = exp_q.pop_front();
      vectors++;
      if (!ok || seen !== exp) begin
        miscompares++;
        $display("FAIL b2b_redirect %0d: got ok=%b pc=%h want %h", t, ok, seen, exp);
      end
    end
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      csr_raddr = 2'(i);
      #1;
      vectors++;
      if (rs1_data !== exp_gpr[i] || rs2_data !== exp_gpr[31 - i]) begin
        miscompares++;
        $display("FAIL b2b_gpr %0d: got %h/%h want %h/%h",
                 i, rs1_data, rs2_data, exp_gpr[i], exp_gpr[31 - i]);
      end
      vectors++;
      if (csr_rdata !== exp_csr_read(2'(i))) begin
        miscompares++;
        $display("FAIL b2b_csr %0d: got %h want %h", i, csr_rdata, exp_csr_read(2'(i)));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    wbu_receive_valid = 1'b0;
    ifu_ready = 1'b0;
    wd = '0; csr_wd = '0; rd = '0; csr_rd = '0; pc = '0; pc_next = '0;
    reg_write_en = 1'b0; csreg_write_en = 1'b0; ecall = 1'b0;
    rs1_addr = '0; rs2_addr = '0; csr_raddr = '0;
    test_reset();
    test_gpr_write();
    test_x0();
    test_backpressure();
    test_rst_in_commit();
`ifdef WBU_CSR_EN
    test_csr_ecall();
`else
    test_no_csr();
`endif
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wbu.md
WBU -- requirements
Module: wbu

Interface
REQ-001 SHALL have parameter REG_NUM, default 32, meaning number of GPRs (x0 hard-wired zero).
REQ-002 SHALL have parameter ECALL_CAUSE, default 32'd11, meaning the mcause value written on ecall.
REQ-003 SHALL have port clk  in  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port wbu_receive_valid  in  1  upstream load/store stage result valid.
REQ-006 SHALL have port wbu_receive_ready  out  1  block can accept a result; equals (state==IDLE).
REQ-007 SHALL have ports wd, csr_wd  in  32 each  GPR write data and CSR write data.
REQ-008 SHALL have ports rd  in  5  GPR index; csr_rd  in  2  CSR index (0 mstatus, 1 mtvec, 2 mepc, 3 mcause).
REQ-009 SHALL have ports reg_write_en, csreg_write_en, ecall  in  1 each  write enables and ecall flag.
REQ-010 SHALL have ports pc, pc_next  in  32 each  retiring instruction PC and its sequential/branch successor.
REQ-011 SHALL have ports wbu_send_valid  out  1, and ifu_ready  in  1  handshake carrying the redirect to fetch.
REQ-012 SHALL have port pc_redirect  out  32  next fetch PC, valid while wbu_send_valid.
REQ-013 SHALL have ports rs1_addr, rs2_addr  in  5; rs1_data, rs2_data  out  32  combinational GPR reads.
REQ-014 SHALL have ports csr_raddr  in  2; csr_rdata  out  32  combinational CSR read.
REQ-015 SHALL have port wbu_state  out  1  busy indicator, high whenever state!=IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> COMMIT -> SEND -> IDLE.
REQ-017 SHALL, in IDLE with wbu_receive_valid=1, latch all inputs at edge T and enter COMMIT; input valid at any other state SHALL be ignored.
REQ-018 SHALL, in COMMIT, write GPR[rd]<=wd when reg_write_en and rd!=0 at edge T+1, then enter SEND.
REQ-019 SHALL, in COMMIT, write CSR[csr_rd]<=csr_wd when csreg_write_en and not ecall.
REQ-020 SHALL, in COMMIT with ecall=1, write mepc<=pc and mcause<=ECALL_CAUSE; any concurrent csreg write SHALL be dropped.
REQ-021 SHALL drive pc_redirect = mtvec (value after COMMIT) when latched ecall, else latched pc_next.
REQ-022 SHALL assert wbu_send_valid from edge T+1 through the cycle ifu_ready=1; pc_redirect SHALL stay stable meanwhile; SEND->IDLE on valid&&ifu_ready.
REQ-023 SHALL return rs1_data/rs2_data = 0 for address 0; writes SHALL become visible to reads the cycle after COMMIT (no bypass).
REQ-024 SHALL ignore writes to x0 and ignore rd >= REG_NUM.
REQ-025 SHALL produce minimum latency of 3 cycles from accepted valid to IDLE (ifu_ready held high).

Reset
REQ-026 SHALL, on rst, set state=IDLE, wbu_send_valid=0, pc_redirect=0, all GPRs=0, mstatus=32'h1800, mtvec=mepc=mcause=0.
REQ-027 SHALL, on rst asserted in COMMIT or SEND, abort without performing the pending write and drop wbu_send_valid the next cycle.

Configuration
REQ-028 SHALL, with WBU_CSR_EN defined, include the four CSRs and the ecall behaviour above.
REQ-029 SHALL, without WBU_CSR_EN, omit CSR storage: csr_rdata=0, CSR writes and ecall trap ignored, pc_redirect always latched pc_next.

Verification
REQ-030 SHALL test: valid with rd=5, wd=32'hDEADBEEF, reg_write_en=1 -> rs1_addr=5 reads 32'hDEADBEEF two cycles after valid, wbu_send_valid with pc_redirect=pc_next.
REQ-031 SHALL test: rd=0, wd=32'h1234, reg_write_en=1 -> rs1_data for x0 remains 0.
REQ-032 SHALL test: csr write mtvec=32'h8000_0100, then ecall with pc=32'h8000_0040 -> mepc=32'h8000_0040, mcause=11, pc_redirect=32'h8000_0100.
REQ-033 SHALL test: ifu_ready held 0 for 4 cycles -> wbu_send_valid and pc_redirect stable, second valid ignored, wbu_receive_ready=0.
REQ-034 SHALL test: rst pulsed in COMMIT with rd=3 write pending -> x3 reads 0, state IDLE, wbu_send_valid=0.
REQ-035 SHALL test: build without WBU_CSR_EN, ecall with pc_next=32'h8000_0004 -> pc_redirect=32'h8000_0004, csr_rdata=0.
